alu_mem: RTL
============

Name: alu_mem

Overview:
- Pipeline boundary register between the execute-stage ALU and the memory/write-back stage.
- Captures the ALU result bundle: write data, write enable, destination register, PC, and instruction.
- Uses a valid/ready handshake with a one-entry skid buffer, so the upstream ready is a registered signal.
- Supports a pipeline flush and exports a forwarding tap for the decode stage's bypass logic.

Parameters:
- XLEN, 32, width of data, PC and instruction fields.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  ALU bundle valid.
- in_ready  output  1  stage can accept; equals NOT skid_valid (registered source).
- reg_wdata_i  input  XLEN  ALU result.
- wr_reg_en_i  input  1  register write enable.
- wr_reg_addr_i  input  REG_AW  destination register.
- pc_i  input  XLEN  instruction PC.
- inst_i  input  XLEN  instruction word.
- flush  input  1  discard all held and incoming bundles.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts.
- reg_wdata_o  output  XLEN  held result.
- wr_reg_en_o  output  1  held write enable.
- wr_reg_addr_o  output  REG_AW  held destination register.
- pc_o  output  XLEN  held PC.
- inst_o  output  XLEN  held instruction.
- fwd_valid  output  1  out_valid AND wr_reg_en_o.
- fwd_addr  output  REG_AW  equals wr_reg_addr_o.
- fwd_data  output  XLEN  equals reg_wdata_o.

Behaviour:
- Storage: main entry M (drives the *_o outputs) and skid entry S, each holding a bundle plus a valid bit.
- accept = in_valid AND in_ready.
- fire = out_valid AND out_ready.
- On capture, wr_reg_en is stored as wr_reg_en_i AND (wr_reg_addr_i != 0). An x0 destination therefore never asserts a write or a forward.
- State machine, encoded by {M.valid, S.valid}:
  - EMPTY (0,0): accept -> ONE, M <= input; otherwise stay in EMPTY.
  - ONE (1,0):
    - accept and fire -> ONE, M <= input.
    - accept and not fire -> FULL, S <= input, M unchanged.
    - fire and not accept -> EMPTY.
    - neither -> ONE, hold.
  - FULL (1,1): in_ready = 0. fire -> ONE, M <= S. Not fire -> hold.
- (0,1) is illegal and unreachable.
- Latency: an accepted bundle appears on *_o in the cycle after acceptance when M is free or firing. Throughput is one bundle per cycle under continuous out_ready.
- Ordering: strictly FIFO. No bundle is duplicated or dropped except by flush.
- flush has priority over every handshake event. Next state is EMPTY, and an input accepted in the flush cycle is discarded. Bundle data registers may keep stale values; only the valid bits are cleared.
- Reset (synchronous, rst high at a rising edge), regardless of state, including mid-stall with FULL:
  - both valid bits, all data fields, out_valid, fwd_valid and all *_o outputs become 0;
  - in_ready becomes 1.
- rst has priority over flush.
- While out_valid = 0, the *_o data values are don't-care to consumers, but they must not change unless a capture occurs.
- fwd_* are combinational functions of M only; S is never forwarded.

Test Plan:
- Reset then single transfer:
  - stimulus: rst 2 cycles; in_valid=1 with reg_wdata_i=0x0000_00F3, addr=5, en=1, pc=0x100, inst=0x0F316293 for 1 cycle; out_ready=1.
  - response: next cycle out_valid=1, reg_wdata_o=0xF3, wr_reg_addr_o=5, fwd_valid=1, fwd_addr=5; the cycle after, out_valid=0.
- Back-pressure and skid:
  - stimulus: out_ready=0; present bundles A (pc 0x100) and B (pc 0x104) on consecutive cycles.
  - response: in_ready drops to 0 the cycle after B is accepted. With out_ready=1, pc_o is 0x100 then 0x104, and in_ready returns to 1 after the first fire.
- Streaming:
  - stimulus: 8 back-to-back bundles with pc 0x200..0x21C; out_ready toggling 1,0,1,0…
  - response: all 8 emerge in order, no duplicates, in_ready never 0 while S is empty.
- x0 suppression:
  - stimulus: bundle with addr=0, en=1, data=0xDEADBEEF.
  - response: wr_reg_en_o=0, fwd_valid=0, reg_wdata_o=0xDEADBEEF.
- Flush while FULL with a simultaneous input:
  - stimulus: reach FULL, then flush=1 in the same cycle as in_valid=1.
  - response: next cycle out_valid=0, in_ready=1, and no bundle ever emerges from these three.
- Reset mid-operation:
  - stimulus: rst=1 while FULL and out_ready=0.
  - response: next cycle all outputs are 0 and in_ready=1; the next bundle transfers normally with 1-cycle latency.

Source files
------------

// File: rtl/alu_mem.sv
// Execute-to-memory pipeline register: one main entry plus a one-entry skid buffer,
// so in_ready is driven straight from a flop. Exposes a forwarding tap off the main entry.
module alu_mem #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   reg_wdata_i,
  input  logic              wr_reg_en_i,
  input  logic [REG_AW-1:0] wr_reg_addr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   inst_i,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   reg_wdata_o,
  output logic              wr_reg_en_o,
  output logic [REG_AW-1:0] wr_reg_addr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   inst_o,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [XLEN-1:0]   fwd_data
);

  localparam int BW = 3 * XLEN + REG_AW + 1;

  // State bits are {main valid, skid valid}; 2'b01 can never be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_m_data;
  logic [BW-1:0]   r_s_data;
  logic [BW-1:0]   w_in_bundle;
  logic            w_accept;
  logic            w_fire;

  // A write to x0 is meaningless, so the enable is dropped at capture time.
  assign w_in_bundle = {reg_wdata_i, wr_reg_en_i & (wr_reg_addr_i != '0),
                        wr_reg_addr_i, pc_i, inst_i};

  assign in_ready  = ~r_state[0];
  assign out_valid = r_state[1];
  assign w_accept  = in_valid & in_ready;
  assign w_fire    = out_valid & out_ready;

  assign {reg_wdata_o, wr_reg_en_o, wr_reg_addr_o, pc_o, inst_o} = r_m_data;

  assign fwd_valid = out_valid & wr_reg_en_o;
  assign fwd_addr  = wr_reg_addr_o;
  assign fwd_data  = reg_wdata_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_m_data <= '0;
      r_s_data <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_m_data <= w_in_bundle;
            r_state  <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_fire) begin
            r_m_data <= w_in_bundle;
          end else if (w_accept) begin
            r_s_data <= w_in_bundle;
            r_state  <= FULL;
          end else if (w_fire) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_fire) begin
            r_m_data <= r_s_data;
            r_state  <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule
